version_reporter: RTL and testbench
===================================

Name: version_reporter

Overview:
- Sequencer that streams the build identity from version_pkg (version, build number, build timestamp) as a framed byte packet on a valid/ready byte interface.
- Sits between the version constants and the host-link transmitter (UART/USB byte stream).
- Lets the host query which bitstream is running. A one-byte live status is appended to every frame.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every frame.
- BEACON_PERIOD, 50_000_000, clk cycles between automatic frames. Used only when VERSION_BEACON_EN is defined; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_i  in  1  single-cycle frame request.
- status_i  in  8  live status byte, sampled at frame start.
- tx_data_o  out  8  frame byte.
- tx_valid_o  out  1  tx_data_o is valid.
- tx_ready_i  in  1  sink accepts the byte when tx_valid_o & tx_ready_i.
- tx_last_o  out  1  high with the final (checksum) byte.
- busy_o  out  1  high while a frame is in flight.
- done_o  out  1  one-cycle pulse after the checksum byte is accepted.
- frame_count_o  out  16  count of completed frames; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (async assert, sync release):
  - tx_valid_o, tx_last_o, busy_o, done_o = 0.
  - tx_data_o = 0; frame_count_o = 0.
  - Byte index and pending flag cleared; state = IDLE.
- Frame order (14 bytes, index 0..13):
  - SYNC_BYTE, C_VERSION_MAJOR, C_VERSION_MINOR, C_VERSION_PATCH, C_VERSION_BUILD.
  - C_VERSION_YEAR[15:8], C_VERSION_YEAR[7:0].
  - MONTH, DAY, HOUR, MINUTE, SECOND.
  - status snapshot.
  - CHECKSUM = sum of bytes 0..12 mod 256.
- States:
  - IDLE: tx_valid_o = 0. On a start trigger (req_i, pending flag, or beacon tick):
    - latch status_i into the snapshot;
    - clear the running sum;
    - set index 0 and enter SEND.
    - Latency: tx_valid_o rises the cycle after req_i.
  - SEND: tx_valid_o = 1, tx_data_o = byte[index].
    - On valid & ready: add byte to the running 8-bit sum (not for index 13) and advance index.
    - tx_last_o = (index == 13).
    - On acceptance of index 13: go to DONE.
  - DONE (1 cycle): done_o = 1, frame_count_o increments, tx_valid_o = 0. Then:
    - pending set: clear it and start the next frame exactly as from IDLE (including status snapshot); tx_valid_o rises the following cycle;
    - otherwise go to IDLE.
- busy_o = 1 in SEND and DONE.
- Handshake rules:
  - tx_data_o and tx_last_o stay stable while tx_valid_o & !tx_ready_i.
  - tx_valid_o never drops mid-frame.
  - One byte per cycle when tx_ready_i is held high: a 14-cycle SEND burst.
- req_i while busy: sets a single-deep pending flag. Further requests coalesce; at most one queued frame.
- req_i in IDLE on the same cycle as a beacon tick: one frame only.
- status_i changes mid-frame: ignored; the snapshot holds until the next frame start.
- Reset mid-frame: frame is abandoned immediately, outputs take reset values, no done_o pulse.
- No combinational path from tx_ready_i or req_i to any output.

Optional Feature:
- Macro: VERSION_BEACON_EN.
- Defined:
  - A free-running counter of width $clog2(BEACON_PERIOD) counts 0..BEACON_PERIOD-1 and wraps.
  - It issues a beacon tick at BEACON_PERIOD-1.
  - A tick is treated exactly like req_i: it starts a frame in IDLE and sets pending when busy.
  - Counter resets to 0 on rst_n.
- Undefined: no counter logic is present. Frames start only from req_i, and BEACON_PERIOD is unused.

Test Plan:
- Single request, ready held high: rst_n deasserted, status_i = 0x00, req_i pulse.
  - tx_valid_o rises the next cycle.
  - 14 consecutive bytes A5 00 00 00 34 20 25 11 05 12 22 09 00 71 (package 0.0.0.52, 2025-11-05 12:22:09).
  - tx_last_o only on 0x71; done_o one cycle after; frame_count_o = 1.
- Backpressure: status_i = 0x5A, tx_ready_i toggles randomly (~50%).
  - Identical byte sequence ending 5A CB.
  - Data and last stable during stalls; no byte dropped or duplicated.
- Coalesced requests: 3 req_i pulses during frame 1 with status_i changed to 0x01 mid-frame.
  - Frame 1 status byte = original snapshot.
  - Exactly one extra frame, carrying status 0x01 and checksum 0x72; frame_count_o = 2.
- Reset mid-frame: assert rst_n low after byte 6 is accepted.
  - All outputs go to 0 asynchronously; no done_o pulse.
  - After release and a new req_i, the frame starts at SYNC_BYTE.
- Counter wrap: force 65536 frames, or preload via hierarchical force to 0xFFFF.
  - frame_count_o goes 0xFFFF -> 0x0000 on done_o.
- VERSION_BEACON_EN defined, BEACON_PERIOD = 100, tx_ready_i = 1, no req_i:
  - frames start every 100 cycles;
  - req_i coincident with a tick yields one frame.
- Same test with the macro undefined: no frames ever start.

Source files
------------

// File: rtl/version_reporter.sv
`timescale 1ns/1ps
// version_reporter: streams the build identity as a 14-byte framed packet on a valid/ready
// byte link. Define VERSION_BEACON_EN to add automatic frames every BEACON_PERIOD cycles.

package version_pkg;
  localparam logic [7:0]  C_VERSION_MAJOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_MINOR  = 8'h00;
  localparam logic [7:0]  C_VERSION_PATCH  = 8'h00;
  localparam logic [7:0]  C_VERSION_BUILD  = 8'h34;
  localparam logic [15:0] C_VERSION_YEAR   = 16'h2025;
  localparam logic [7:0]  C_VERSION_MONTH  = 8'h11;
  localparam logic [7:0]  C_VERSION_DAY    = 8'h05;
  localparam logic [7:0]  C_VERSION_HOUR   = 8'h12;
  localparam logic [7:0]  C_VERSION_MINUTE = 8'h22;
  localparam logic [7:0]  C_VERSION_SECOND = 8'h09;
endpackage

module version_reporter
  import version_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned BEACON_PERIOD = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic [7:0]  status_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        tx_last_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] frame_count_o
);

  localparam logic [3:0] LAST_IDX = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t      state_reg;
  logic [3:0]  index_reg;
  logic [7:0]  sum_reg;
  logic [7:0]  status_snap_reg;
  logic        pending_reg;
  logic [7:0]  tx_data_reg;
  logic        tx_valid_reg;
  logic        tx_last_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [15:0] frame_count_reg;

  logic        beacon_tick;
  logic        start_req;
  logic        start_frame;
  logic        accept;
  logic [7:0]  sum_plus;
  logic [3:0]  next_index;

  // Byte at a given frame position; index 13 carries the checksum passed in as sum.
  function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                            input logic [7:0] snap,
                                            input logic [7:0] sum);
    logic [7:0] b;
    case (idx)
      4'd0:    b = SYNC_BYTE;
      4'd1:    b = C_VERSION_MAJOR;
      4'd2:    b = C_VERSION_MINOR;
      4'd3:    b = C_VERSION_PATCH;
      4'd4:    b = C_VERSION_BUILD;
      4'd5:    b = C_VERSION_YEAR[15:8];
      4'd6:    b = C_VERSION_YEAR[7:0];
      4'd7:    b = C_VERSION_MONTH;
      4'd8:    b = C_VERSION_DAY;
      4'd9:    b = C_VERSION_HOUR;
      4'd10:   b = C_VERSION_MINUTE;
      4'd11:   b = C_VERSION_SECOND;
      4'd12:   b = snap;
      default: b = sum;
    endcase
    return b;
  endfunction

`ifdef VERSION_BEACON_EN
  localparam int unsigned          BEACON_W    = $clog2(BEACON_PERIOD);
  localparam logic [BEACON_W-1:0]  BEACON_LAST = BEACON_W'(BEACON_PERIOD - 1);

  logic [BEACON_W-1:0] beacon_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beacon_cnt_reg <= '0;
    end else if (beacon_cnt_reg == BEACON_LAST) begin
      beacon_cnt_reg <= '0;
    end else begin
      beacon_cnt_reg <= beacon_cnt_reg + BEACON_W'(1);
    end
  end

  assign beacon_tick = (beacon_cnt_reg == BEACON_LAST);
`else
  assign beacon_tick = 1'b0;
`endif

  assign start_req  = req_i | beacon_tick;
  assign accept     = tx_valid_reg & tx_ready_i;
  assign sum_plus   = sum_reg + tx_data_reg;
  assign next_index = index_reg + 4'd1;

  // A queued request restarts straight out of DONE without passing through IDLE.
  assign start_frame = ((state_reg == S_IDLE) & (start_req | pending_reg)) |
                       ((state_reg == S_DONE) & pending_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= S_IDLE;
      index_reg       <= 4'd0;
      sum_reg         <= 8'd0;
      status_snap_reg <= 8'd0;
      pending_reg     <= 1'b0;
      tx_data_reg     <= 8'd0;
      tx_valid_reg    <= 1'b0;
      tx_last_reg     <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      frame_count_reg <= 16'd0;
    end else begin
      done_reg <= 1'b0;
      if (start_frame) begin
        state_reg       <= S_SEND;
        status_snap_reg <= status_i;
        sum_reg         <= 8'd0;
        index_reg       <= 4'd0;
        tx_data_reg     <= SYNC_BYTE;
        tx_valid_reg    <= 1'b1;
        tx_last_reg     <= 1'b0;
        busy_reg        <= 1'b1;
        // A request landing on the DONE restart cycle is itself a request while busy.
        pending_reg     <= (state_reg == S_DONE) ? start_req : 1'b0;
      end else begin
        case (state_reg)
          S_SEND: begin
            if (start_req) begin
              pending_reg <= 1'b1;
            end
            if (accept) begin
              if (index_reg == LAST_IDX) begin
                state_reg       <= S_DONE;
                tx_valid_reg    <= 1'b0;
                tx_last_reg     <= 1'b0;
                tx_data_reg     <= 8'd0;
                done_reg        <= 1'b1;
                frame_count_reg <= frame_count_reg + 16'd1;
              end else begin
                sum_reg     <= sum_plus;
                index_reg   <= next_index;
                tx_data_reg <= frame_byte(next_index, status_snap_reg, sum_plus);
                tx_last_reg <= (next_index == LAST_IDX);
              end
            end
          end
          S_DONE: begin
            pending_reg <= start_req;
            state_reg   <= S_IDLE;
            busy_reg    <= 1'b0;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign tx_data_o     = tx_data_reg;
  assign tx_valid_o    = tx_valid_reg;
  assign tx_last_o     = tx_last_reg;
  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign frame_count_o = frame_count_reg;

endmodule

// File: tb/tb_version_reporter.sv
`timescale 1ns/1ps
// Directed bench for version_reporter: table of single frames, then coalescing,
// mid-frame reset, frame counter wrap and beacon (or its absence) sequences.

module tb_version_reporter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [7:0]  status_i = 8'h00;
  logic        tx_ready_i = 1'b1;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_last_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] frame_count_o;

  version_reporter #(
    .SYNC_BYTE    (8'hA5),
    .BEACON_PERIOD(100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .status_i     (status_i),
    .tx_data_o    (tx_data_o),
    .tx_valid_o   (tx_valid_o),
    .tx_ready_i   (tx_ready_i),
    .tx_last_o    (tx_last_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .frame_count_o(frame_count_o)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_count = 16'd0;
  time         rise1;
  time         rise2;
  int          seen;

  // Fixed identity bytes 0..11 of package 0.0.0.52 built 2025-11-05 12:22:09.
  logic [7:0] hdr_bytes [12] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h34, 8'h20,
                                 8'h25, 8'h11, 8'h05, 8'h12, 8'h22, 8'h09};

  typedef struct packed {
    logic [7:0] status;
    logic       bp;
    logic [7:0] cksum;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Called on a negedge; leaves req_i low on the following negedge.
  task automatic pulse_req(input logic [7:0] st);
    status_i = st;
    req_i    = 1'b1;
    @(negedge clk);
    req_i    = 1'b0;
  endtask

  // Receives one frame starting at the current negedge, then checks the done pulse.
  task automatic recv_frame(input string tag, input logic bp,
                            input logic [7:0] exp_status, input logic [7:0] exp_ck);
    logic [7:0] got [14];
    logic [7:0] exp_b;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    logic       stalled = 1'b0;
    logic       gap = 1'b0;
    int         n = 0;
    int         cyc = 0;
    while (n < 14 && cyc < 300) begin
      if (stalled) begin
        check({tag, " stall_hold"}, 16'({tx_valid_o, tx_last_o, tx_data_o}),
              16'({1'b1, prev_last, prev_data}));
      end else if (n > 0 && !tx_valid_o) begin
        gap = 1'b1;
      end
      tx_ready_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = 1'b0;
      if (tx_valid_o) begin
        if (tx_ready_i) begin
          got[n] = tx_data_o;
          check($sformatf("%s last@%0d", tag, n), 16'(tx_last_o), 16'(n == 13));
          n++;
        end else begin
          stalled   = 1'b1;
          prev_data = tx_data_o;
          prev_last = tx_last_o;
        end
      end
      @(negedge clk);
      cyc++;
    end
    tx_ready_i = 1'b1;
    check({tag, " bytes_received"}, 16'(n), 16'd14);
    check({tag, " valid_gap"}, 16'(gap), 16'd0);
    for (int i = 0; i < n; i++) begin
      exp_b = (i < 12) ? hdr_bytes[i] : ((i == 12) ? exp_status : exp_ck);
      check($sformatf("%s byte%0d", tag, i), 16'(got[i]), 16'(exp_b));
    end
    exp_count = exp_count + 16'd1;
    check({tag, " done_pulse"}, 16'(done_o), 16'd1);
    check({tag, " frame_count"}, frame_count_o, exp_count);
    $display("frame %s: status=%02h cksum=%02h count=%0d cycles=%0d",
             tag, (n > 12) ? got[12] : 8'h00, (n > 13) ? got[13] : 8'h00, frame_count_o, cyc);
    @(negedge clk);
    check({tag, " done_clear"}, 16'(done_o), 16'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{status: 8'h00, bp: 1'b0, cksum: 8'h71};
    vecs[1] = '{status: 8'h5A, bp: 1'b1, cksum: 8'hCB};
    vecs[2] = '{status: 8'hFF, bp: 1'b0, cksum: 8'h70};
    vecs[3] = '{status: 8'h8F, bp: 1'b1, cksum: 8'h00};

    repeat (3) @(negedge clk);
    check("reset valid", 16'(tx_valid_o), 16'd0);
    check("reset last", 16'(tx_last_o), 16'd0);
    check("reset busy", 16'(busy_o), 16'd0);
    check("reset done", 16'(done_o), 16'd0);
    check("reset data", 16'(tx_data_o), 16'd0);
    check("reset count", frame_count_o, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef VERSION_BEACON_EN
    seen = 0;
    while (!tx_valid_o && seen < 150) begin
      @(negedge clk);
      seen++;
    end
    check("beacon first_start", 16'(tx_valid_o), 16'd1);
    rise1 = $time;
    recv_frame("beacon1", 1'b0, 8'h00, 8'h71);
    seen = 0;
    while (!tx_valid_o && seen < 150) begin
      @(negedge clk);
      seen++;
    end
    rise2 = $time;
    check("beacon period", 16'((rise2 - rise1) / 10), 16'd100);
    recv_frame("beacon2", 1'b0, 8'h00, 8'h71);
    while ($time < rise2 + 990) @(negedge clk);
    pulse_req(8'h00);
    check("beacon+req start", 16'(tx_valid_o), 16'd1);
    recv_frame("beacon3", 1'b0, 8'h00, 8'h71);
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (tx_valid_o) seen++;
    end
    check("beacon+req single_frame", 16'(seen), 16'd0);
`else
    for (int i = 0; i < 4; i++) begin
      pulse_req(vecs[i].status);
      check($sformatf("vec%0d start_latency", i), 16'(tx_valid_o), 16'd1);
      check($sformatf("vec%0d busy", i), 16'(busy_o), 16'd1);
      recv_frame($sformatf("vec%0d", i), vecs[i].bp, vecs[i].status, vecs[i].cksum);
      check($sformatf("vec%0d idle_after", i), 16'({busy_o, tx_valid_o}), 16'd0);
      repeat (2) @(negedge clk);
    end

    // Three requests during frame 1 collapse into one queued frame.
    pulse_req(8'h10);
    fork
      recv_frame("coal1", 1'b0, 8'h10, 8'h81);
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          req_i = 1'b1;
          if (k == 0) status_i = 8'h01;
          @(negedge clk);
          req_i = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
    join
    check("coal2 restart", 16'(tx_valid_o), 16'd1);
    recv_frame("coal2", 1'b0, 8'h01, 8'h72);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_valid_o) seen++;
    end
    check("coal no_third_frame", 16'(seen), 16'd0);

    // Reset after byte 6 is accepted.
    tx_ready_i = 1'b1;
    pulse_req(8'h00);
    repeat (7) @(negedge clk);
    check("midrst byte7_presented", 16'(tx_data_o), 16'h0011);
    rst_n = 1'b0;
    #1;
    check("midrst async outputs", 16'({tx_valid_o, tx_last_o, busy_o, done_o, tx_data_o}), 16'd0);
    check("midrst count", frame_count_o, 16'd0);
    exp_count = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst no_done", 16'({done_o, tx_valid_o}), 16'd0);
    pulse_req(8'h00);
    check("midrst restart_sync", 16'(tx_data_o), 16'h00A5);
    recv_frame("post_rst", 1'b0, 8'h00, 8'h71);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count_reg;
    exp_count = 16'hFFFF;
    @(negedge clk);
    pulse_req(8'h00);
    recv_frame("wrap", 1'b0, 8'h00, 8'h71);

    // Without the beacon nothing may start on its own.
    seen = 0;
    repeat (250) begin
      @(negedge clk);
      if (tx_valid_o || busy_o) seen++;
    end
    check("no_beacon idle", 16'(seen), 16'd0);
    check("no_beacon count", frame_count_o, exp_count);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
